// File: rtl/evt2_uart_framer_if.sv
// Bus bundle between the UART byte source, the EVT2 word sink and the framer.
// The framer uses the slave modport; the byte source / word sink side uses master.
interface evt2_uart_framer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] evt_word;
  logic        evt_word_valid;
  logic        evt_word_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic        framing_error;
  logic [7:0]  drop_count;

  modport slave (
    input  rx_data, rx_valid, evt_word_ready,
    output evt_word, evt_word_valid, cmd_valid, cmd_code, framing_error, drop_count
  );

  modport master (
    output rx_data, rx_valid, evt_word_ready,
    input  evt_word, evt_word_valid, cmd_valid, cmd_code, framing_error, drop_count
  );
endinterface

// File: rtl/evt2_uart_framer.sv
// Assembles MSB-first UART bytes into 32-bit EVT2 words behind a 2-entry FIFO,
// detecting gap-qualified command bytes and discarding stale partial words.
module evt2_uart_framer #(
  parameter int unsigned CLKS_PER_BIT  = 104,
  parameter int unsigned CMD_GAP_BYTES = 2,
  parameter int unsigned RESYNC_BYTES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  evt2_uart_framer_if.slave   bus
);

  localparam int unsigned BYTE_CYCLES    = CLKS_PER_BIT * 10;
  localparam int unsigned CMD_GAP_CYCLES = BYTE_CYCLES * CMD_GAP_BYTES;
  localparam int unsigned TIMEOUT_CYCLES = BYTE_CYCLES * RESYNC_BYTES;
  localparam int unsigned IDLE_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned CNT_W          = 2;
  localparam int unsigned DROP_W         = 8;

  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_GAP = IDLE_W'(CMD_GAP_CYCLES);

  typedef enum logic [1:0] {B0, B1, B2, B3} state_e;

  state_e              state_q, state_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [23:0]         part_q, part_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [1:0]          cmd_code_q, cmd_code_d;
  logic                ferr_q, ferr_d;
  logic [WORD_W-1:0]   head_q, head_d;
  logic [WORD_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                cmd_allowed_c;
  logic                timeout_c;
  logic                is_cmd_c;
  logic                push_c;
  logic                pop_c;
  logic                full_c;
  logic                push_ok_c;
  logic [WORD_W-1:0]   new_word_c;

  // Idle counter: cycles since the last received byte, saturating at the timeout
  always_comb begin
    idle_d = idle_q;
    if (bus.rx_valid)            idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
  end

  assign cmd_allowed_c = (idle_q >= IDLE_GAP);
  assign timeout_c     = (idle_q == IDLE_MAX) && !bus.rx_valid;
  assign is_cmd_c      = (bus.rx_data[7:2] == 6'b111111);
  assign new_word_c    = {part_q, bus.rx_data};

  // Byte assembly FSM; 0xFF..0xFC map to codes 0..3, i.e. the inverted low bits
  always_comb begin
    state_d     = state_q;
    part_d      = part_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    ferr_d      = 1'b0;
    push_c      = 1'b0;
    unique case (state_q)
      B0: begin
        if (bus.rx_valid) begin
          if (is_cmd_c && cmd_allowed_c) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = ~bus.rx_data[1:0];
          end else begin
            part_d[23:16] = bus.rx_data;
            state_d       = B1;
          end
        end
      end
      B1: begin
        if (bus.rx_valid) begin
          part_d[15:8] = bus.rx_data;
          state_d      = B2;
        end else if (timeout_c) begin
          ferr_d  = 1'b1;
          state_d = B0;
        end
      end
      B2: begin
        if (bus.rx_valid) begin
          part_d[7:0] = bus.rx_data;
          state_d     = B3;
        end else if (timeout_c) begin
          ferr_d  = 1'b1;
          state_d = B0;
        end
      end
      B3: begin
        if (bus.rx_valid) begin
          push_c  = 1'b1;
          state_d = B0;
        end else if (timeout_c) begin
          ferr_d  = 1'b1;
          state_d = B0;
        end
      end
      default: state_d = B0;
    endcase
  end

  assign pop_c     = valid_q && bus.evt_word_ready;
  assign full_c    = (count_q == CNT_W'(2));
  assign push_ok_c = push_c && (!full_c || pop_c);

  // Two-entry FIFO kept as registered head/tail so the output word is a flop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    unique case ({push_ok_c, pop_c})
      2'b10: begin
        if (count_q == '0) head_d = new_word_c;
        else               tail_d = new_word_c;
        count_d = count_q + CNT_W'(1);
      end
      2'b01: begin
        if (count_q == CNT_W'(2)) head_d = tail_q;
        count_d = count_q - CNT_W'(1);
      end
      2'b11: begin
        if (count_q == CNT_W'(1)) begin
          head_d = new_word_c;
        end else begin
          head_d = tail_q;
          tail_d = new_word_c;
        end
      end
      default: ;
    endcase
    if (push_c && full_c && !pop_c && (drop_q != '1))
      drop_d = drop_q + DROP_W'(1);
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= B0;
      idle_q      <= IDLE_MAX;
      part_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      ferr_q      <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      part_q      <= part_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      ferr_q      <= ferr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.evt_word       = head_q;
  assign bus.evt_word_valid = valid_q;
  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.cmd_code       = cmd_code_q;
  assign bus.framing_error  = ferr_q;
  assign bus.drop_count     = drop_q;

endmodule

// File: tb/tb_evt2_uart_framer.sv
// Directed bench for evt2_uart_framer with CLKS_PER_BIT=4 (byte = 40 cycles,
// command gap = 80 cycles, partial-word timeout = 160 cycles).
module tb_evt2_uart_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  evt2_uart_framer_if bus ();

  evt2_uart_framer #(
    .CLKS_PER_BIT (4),
    .CMD_GAP_BYTES(2),
    .RESYNC_BYTES (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One-cycle strobe; returns on the falling edge after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Strobe placed 40 cycles after the previous one
  task automatic gap_byte(input logic [7:0] b);
    repeat (38) @(negedge clk);
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    gap_byte(w[23:16]);
    gap_byte(w[15:8]);
    gap_byte(w[7:0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word"},  bus.evt_word,       32'h0);
    check({tag, "_valid"}, bus.evt_word_valid, 32'h0);
    check({tag, "_cmdv"},  bus.cmd_valid,      32'h0);
    check({tag, "_code"},  bus.cmd_code,       32'h0);
    check({tag, "_ferr"},  bus.framing_error,  32'h0);
    check({tag, "_drop"},  bus.drop_count,     32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.evt_word_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs(tag);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int fe_cnt;
    int fe_at;
    int vseen;
    bus.rx_data        = 8'h00;
    bus.rx_valid       = 1'b0;
    bus.evt_word_ready = 1'b1;

    do_reset("rst0");

    // First byte after reset qualifies as a command
    send_byte(8'hFE);
    check("cmd_fe_valid", bus.cmd_valid, 32'h1);
    check("cmd_fe_code",  bus.cmd_code,  32'h1);
    check("cmd_fe_noword", bus.evt_word_valid, 32'h0);
    @(negedge clk);
    check("cmd_fe_pulse", bus.cmd_valid, 32'h0);

    // 0xFF only 40 cycles later is data, not a command
    gap_byte(8'hFF);
    check("ff_not_cmd", bus.cmd_valid, 32'h0);
    gap_byte(8'h00);
    gap_byte(8'h00);
    gap_byte(8'h01);
    check("w_ff_valid", bus.evt_word_valid, 32'h1);
    check("w_ff_data",  bus.evt_word,       32'hFF000001);
    check("w_ff_nocmd", bus.cmd_valid,      32'h0);
    @(negedge clk);
    check("w_ff_pop", bus.evt_word_valid, 32'h0);

    // Basic word assembly
    send_word(32'h12345678);
    check("w_1234_valid", bus.evt_word_valid, 32'h1);
    check("w_1234_data",  bus.evt_word,       32'h12345678);
    @(negedge clk);
    check("w_1234_pop", bus.evt_word_valid, 32'h0);

    // Partial word times out
    send_byte(8'hAB);
    gap_byte(8'hCD);
    fe_cnt = 0;
    fe_at  = -1;
    vseen  = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.framing_error === 1'b1) begin
        fe_cnt++;
        fe_at = i;
      end
      if (bus.evt_word_valid === 1'b1) vseen++;
    end
    check("ferr_count",  32'(fe_cnt), 32'd1);
    check("ferr_timing", 32'((fe_at >= 159) && (fe_at <= 163)), 32'd1);
    check("ferr_noword", 32'(vseen), 32'd0);
    send_word(32'h01020304);
    check("w_0102_valid", bus.evt_word_valid, 32'h1);
    check("w_0102_data",  bus.evt_word,       32'h01020304);

    // Long idle, then soft-reset command; code held afterwards
    repeat (100) @(negedge clk);
    send_byte(8'hFC);
    check("cmd_fc_valid", bus.cmd_valid, 32'h1);
    check("cmd_fc_code",  bus.cmd_code,  32'h3);
    @(negedge clk);
    check("cmd_fc_pulse", bus.cmd_valid, 32'h0);
    check("cmd_fc_hold",  bus.cmd_code,  32'h3);

    // Back-pressure: third word dropped, first two kept in order
    bus.evt_word_ready = 1'b0;
    send_word(32'hA1A2A3A4);
    check("bp_a_valid", bus.evt_word_valid, 32'h1);
    check("bp_a_data",  bus.evt_word,       32'hA1A2A3A4);
    send_word(32'hB1B2B3B4);
    check("bp_b_stable", bus.evt_word, 32'hA1A2A3A4);
    check("bp_b_drop",   bus.drop_count, 32'h0);
    send_word(32'hC1C2C3C4);
    check("bp_c_drop",   bus.drop_count, 32'h1);
    check("bp_c_stable", bus.evt_word,   32'hA1A2A3A4);
    bus.evt_word_ready = 1'b1;
    @(negedge clk);
    check("bp_pop1_valid", bus.evt_word_valid, 32'h1);
    check("bp_pop1_data",  bus.evt_word,       32'hB1B2B3B4);
    @(negedge clk);
    check("bp_pop2_valid", bus.evt_word_valid, 32'h0);

    do_reset("rst1");

    // Full FIFO with a pop on the completing strobe: no drop
    bus.evt_word_ready = 1'b0;
    send_word(32'hD1D2D3D4);
    send_word(32'hE1E2E3E4);
    send_byte(8'hF1);
    gap_byte(8'hF2);
    gap_byte(8'hF3);
    repeat (38) @(negedge clk);
    @(negedge clk);
    bus.rx_data        = 8'hF4;
    bus.rx_valid       = 1'b1;
    bus.evt_word_ready = 1'b1;
    @(negedge clk);
    bus.rx_valid       = 1'b0;
    bus.evt_word_ready = 1'b0;
    check("pp_drop",  bus.drop_count,     32'h0);
    check("pp_valid", bus.evt_word_valid, 32'h1);
    check("pp_head",  bus.evt_word,       32'hE1E2E3E4);
    bus.evt_word_ready = 1'b1;
    @(negedge clk);
    check("pp_third", bus.evt_word,       32'hF1F2F3F4);
    check("pp_third_valid", bus.evt_word_valid, 32'h1);
    @(negedge clk);
    check("pp_empty", bus.evt_word_valid, 32'h0);

    // Asynchronous reset mid-word with one word buffered
    bus.evt_word_ready = 1'b0;
    send_word(32'h5A5B5C5D);
    check("ar_buf_valid", bus.evt_word_valid, 32'h1);
    send_byte(8'h66);
    gap_byte(8'h77);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("ar");
    @(negedge clk);
    rst = 1'b0;
    bus.evt_word_ready = 1'b1;
    send_word(32'h11223344);
    check("ar_fresh_valid", bus.evt_word_valid, 32'h1);
    check("ar_fresh_data",  bus.evt_word,       32'h11223344);
    check("ar_fresh_drop",  bus.drop_count,     32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/evt2_uart_framer.md
EVT2_UART_FRAMER -- requirements
Module: evt2_uart_framer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, UART bit period in clk cycles; BYTE_CYCLES = CLKS_PER_BIT*10.
REQ-002 Parameter CMD_GAP_BYTES, default 2, idle gap in bytes that qualifies a command byte; CMD_GAP_CYCLES = BYTE_CYCLES*CMD_GAP_BYTES.
REQ-003 Parameter RESYNC_BYTES, default 4, inter-byte timeout in bytes for a partial word; TIMEOUT_CYCLES = BYTE_CYCLES*RESYNC_BYTES; RESYNC_BYTES SHALL be greater than CMD_GAP_BYTES.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  8  received UART byte.
REQ-007 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-008 evt_word  output  32  FIFO head EVT2 word, MSB-first assembled.
REQ-009 evt_word_valid  output  1  FIFO non-empty.
REQ-010 evt_word_ready  input  1  downstream accepts head when high with valid.
REQ-011 cmd_valid  output  1  one-cycle pulse, command byte detected.
REQ-012 cmd_code  output  2  0=0xFF echo, 1=0xFE status, 2=0xFD config, 3=0xFC soft reset; held until next command.
REQ-013 framing_error  output  1  one-cycle pulse, partial word discarded on timeout.
REQ-014 drop_count  output  8  saturating count of complete words lost to full FIFO.

Function
REQ-015 Idle counter SHALL clear on rx_valid, else increment by 1 per cycle, saturating at TIMEOUT_CYCLES; command_allowed = idle counter >= CMD_GAP_CYCLES.
REQ-016 Assembly FSM SHALL have states B0, B1, B2, B3; B0 expects MSB byte [31:24], B1 [23:16], B2 [15:8], B3 [7:0].
REQ-017 In B0 with rx_valid, rx_data in 0xFC..0xFF and command_allowed: cmd_valid SHALL pulse the next cycle with mapped cmd_code; FSM stays B0; byte not stored.
REQ-018 In B0 with rx_valid, any other byte (including 0xFC..0xFF without command_allowed): store as [31:24], go B1.
REQ-019 B1->B2->B3 on each rx_valid storing the byte; B3 on rx_valid completes the word and returns to B0.
REQ-020 In B1..B3 with idle counter saturated and no rx_valid: discard partial word, go B0, pulse framing_error next cycle.
REQ-021 Completed word SHALL be pushed into a 2-entry FIFO; evt_word_valid high the cycle after the 4th-byte rx_valid (latency 1).
REQ-022 Pop when evt_word_valid and evt_word_ready; evt_word then shows the next entry the following cycle.
REQ-023 Push with FIFO full and no simultaneous pop: word dropped, drop_count +1, saturating at 255; FSM still returns B0.
REQ-024 Push with FIFO full and simultaneous pop: push accepted, no drop.
REQ-025 Push and pop on empty FIFO: word enters FIFO, valid asserts next cycle (no bypass).
REQ-026 evt_word SHALL be stable while evt_word_valid is high and not popped.

Reset
REQ-027 On rst: FSM B0, FIFO empty, evt_word 0, evt_word_valid 0, cmd_valid 0, cmd_code 0, framing_error 0, drop_count 0, idle counter TIMEOUT_CYCLES (first byte after reset may be a command).
REQ-028 rst asserted mid-word or mid-pop SHALL discard all partial and buffered state immediately, without waiting for a clock edge.

Verification (CLKS_PER_BIT=4: BYTE_CYCLES=40, CMD_GAP_CYCLES=80, TIMEOUT_CYCLES=160)
REQ-029 Bytes 0x12,0x34,0x56,0x78 at 40-cycle spacing, ready=1 -> evt_word=0x12345678, valid high for 1 cycle, 1 cycle after 4th strobe.
REQ-030 After reset, 0xFE immediately -> cmd_valid pulse, cmd_code=1, no word; then 0xFF,0x00,0x00,0x01 at 40-cycle spacing -> word 0xFF000001, no cmd_valid.
REQ-031 Bytes 0xAB,0xCD then 200 idle cycles -> framing_error pulse at idle cycle 160; then 0x01,0x02,0x03,0x04 -> word 0x01020304.
REQ-032 ready=0, send 3 complete words -> first two buffered in order, drop_count=1; raise ready -> two pops, valid drops.
REQ-033 ready=0, FIFO full, ready pulsed on the 4th-byte strobe cycle of a third word -> drop_count stays 0, third word delivered.
REQ-034 Assert rst after 2 bytes of a word with one word buffered -> outputs at reset values asynchronously; next 4 bytes form a fresh word.
